// File: rtl/cpu_multisim_sink.sv
// Sink for the per-CPU multisim stream: DEPTH-entry FIFO plus word count, XOR checksum and peak occupancy.
// Latency: 1 cycle from an accepted word to out_vld; there is no bypass path when empty.
// Backpressure: data_rdy depends only on registered occupancy (and the LFSR when CPU_MULTISIM_SINK_THROTTLE_EN is defined).
module cpu_multisim_sink #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    data_vld,
   input  logic [63:0]             data,
   output logic                    data_rdy,
   output logic                    out_vld,
   output logic [63:0]             out_data,
   input  logic                    out_rdy,
   output logic [CNT_W-1:0]        word_cnt,
   output logic [63:0]             checksum,
   output logic [$clog2(DEPTH):0]  peak_occ
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

   logic [63:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;
   logic             space;
   logic             push;
   logic             pop;

   // A full FIFO refuses a word even if the head is popped in the same cycle,
   // which keeps out_rdy off the upstream ready path.
   assign space = (occ != FULL);

`ifdef CPU_MULTISIM_SINK_THROTTLE_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Fibonacci taps 16,14,13,11.
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Free-running LFSR; its low bit injects pseudo-random backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   assign data_rdy = rst_n && space && !lfsr[0];
`else
   assign data_rdy = rst_n && space;
`endif

   assign push    = data_vld && data_rdy;
   assign out_vld = (occ != '0);
   assign pop     = out_vld && out_rdy;

   // Storage is not reset; masking the read keeps out_data at zero while empty.
   assign out_data = out_vld ? mem[rd_ptr] : '0;

   // Next occupancy: simultaneous push and pop leaves it unchanged.
   always_comb begin
      occ_nxt = occ;
      case ({push, pop})
         2'b10:   occ_nxt = occ + 1'b1;
         2'b01:   occ_nxt = occ - 1'b1;
         default: occ_nxt = occ;
      endcase
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occ <= occ_nxt;
      end
   end

   // End-of-test statistics: saturating word count, XOR checksum, peak occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         checksum <= '0;
         peak_occ <= '0;
      end else begin
         if (push) begin
            checksum <= checksum ^ data;
            if (word_cnt != '1) begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
         if (occ_nxt > peak_occ) begin
            peak_occ <= occ_nxt;
         end
      end
   end

endmodule

// File: tb/tb_cpu_multisim_sink.sv
// Directed bench for cpu_multisim_sink (DEPTH=4) plus a narrow-counter instance for saturation.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
// A random stream phase runs in both builds; directed phases assume no throttling.
module tb_cpu_multisim_sink;

   localparam int DEPTH = 4;
   localparam int N     = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_vld;
   logic [63:0] data;
   logic        data_rdy;
   logic        out_vld;
   logic [63:0] out_data;
   logic        out_rdy;
   logic [31:0] word_cnt;
   logic [63:0] checksum;
   logic [2:0]  peak_occ;

   logic        s_data_rdy;
   logic        s_out_vld;
   logic [63:0] s_out_data;
   logic [2:0]  s_word_cnt;
   logic [63:0] s_checksum;
   logic [2:0]  s_peak_occ;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_multisim_sink #(.DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_vld (data_vld),
      .data     (data),
      .data_rdy (data_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_rdy  (out_rdy),
      .word_cnt (word_cnt),
      .checksum (checksum),
      .peak_occ (peak_occ)
   );

   cpu_multisim_sink #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_vld (data_vld),
      .data     (data),
      .data_rdy (s_data_rdy),
      .out_vld  (s_out_vld),
      .out_data (s_out_data),
      .out_rdy  (out_rdy),
      .word_cnt (s_word_cnt),
      .checksum (s_checksum),
      .peak_occ (s_peak_occ)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      data_vld = 1'b0;
      data     = '0;
      out_rdy  = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
   endtask

   logic [63:0] words [N];
   logic [63:0] xor_model;
   int sent;
   int rcv;
   int occ_model;
   int throttled;
   int cyc;
   bit do_push;
   bit do_pop;

   initial begin
      rst_n    = 1'b0;
      data_vld = 1'b0;
      data     = '0;
      out_rdy  = 1'b0;
      #2;
      check("rst_data_rdy", data_rdy, 0);
      check("rst_out_vld",  out_vld,  0);
      check("rst_out_data", out_data, 0);
      #10;
      rst_n = 1'b1;
      step();

`ifndef CPU_MULTISIM_SINK_THROTTLE_EN
      // Idle after reset
      check("idle_data_rdy", data_rdy, 1);
      check("idle_out_vld",  out_vld,  0);
      check("idle_word_cnt", word_cnt, 0);
      check("idle_checksum", checksum, 0);
      check("idle_peak_occ", peak_occ, 0);

      // Two words passing straight through
      out_rdy  = 1'b1;
      data_vld = 1'b1;
      data     = 64'h1;
      step();
      check("pass1_out_vld",  out_vld,  1);
      check("pass1_out_data", out_data, 64'h1);
      data = 64'h2;
      step();
      check("pass2_out_vld",  out_vld,  1);
      check("pass2_out_data", out_data, 64'h2);
      data_vld = 1'b0;
      step();
      check("pass_drained",   out_vld,  0);
      check("pass_word_cnt",  word_cnt, 2);
      check("pass_checksum",  checksum, 64'h3);
      check("pass_peak_occ",  peak_occ, 1);

      // Fill to full with the consumer stalled
      out_rdy  = 1'b0;
      data_vld = 1'b1;
      data = 64'h10; step();
      check("fill1_data_rdy", data_rdy, 1);
      data = 64'h11; step();
      data = 64'h12; step();
      check("fill3_data_rdy", data_rdy, 1);
      data = 64'h13; step();
      check("full_data_rdy",  data_rdy, 0);
      check("full_peak_occ",  peak_occ, 4);
      data = 64'h14; step();
      check("held_data_rdy",  data_rdy, 0);
      check("held_word_cnt",  word_cnt, 6);
      check("held_out_data",  out_data, 64'h10);
      out_rdy = 1'b1;
      step();
      check("pop1_out_data",  out_data, 64'h11);
      check("pop1_data_rdy",  data_rdy, 1);
      check("pop1_word_cnt",  word_cnt, 6);
      step();
      check("late_word_cnt",  word_cnt, 7);
      check("late_out_data",  out_data, 64'h12);
      data_vld = 1'b0;
      step();
      check("order_13",       out_data, 64'h13);
      step();
      check("order_14",       out_data, 64'h14);
      step();
      check("fill_drained",   out_vld,  0);
      check("fill_checksum",  checksum, 64'h17);
      check("fill_peak_occ",  peak_occ, 4);
      check("sat_cnt_7",      s_word_cnt, 3'd7);

      // Steady push+pop at occupancy 2, pointers wrap several times
      do_reset();
      step();
      check("wrap_rst_peak",  peak_occ, 0);
      data_vld = 1'b1;
      for (int i = 0; i < 2; i++) begin
         data = 64'hC0DE_0000_0000_0000 + 64'(i);
         step();
      end
      out_rdy = 1'b1;
      for (int j = 0; j < 20; j++) begin
         data = 64'hC0DE_0000_0000_0000 + 64'(j + 2);
         step();
         check("wrap_out_data", out_data, 64'hC0DE_0000_0000_0000 + 64'(j + 1));
         check("wrap_data_rdy", data_rdy, 1);
      end
      data_vld = 1'b0;
      step();
      check("wrap_tail",      out_data, 64'hC0DE_0000_0000_0015);
      step();
      check("wrap_empty",     out_vld,  0);
      check("wrap_word_cnt",  word_cnt, 22);
      check("wrap_checksum",  checksum, 64'h1);
      check("wrap_peak_occ",  peak_occ, 2);
      check("sat_cnt_hold",   s_word_cnt, 3'd7);

      // Asynchronous reset in the middle of a cycle with three words buffered
      out_rdy  = 1'b0;
      data_vld = 1'b1;
      data = 64'hA; step();
      data = 64'hB; step();
      data = 64'hC; step();
      data_vld = 1'b0;
      check("pre_rst_peak",   peak_occ, 3);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_vld",   out_vld,  0);
      check("arst_out_data",  out_data, 0);
      check("arst_data_rdy",  data_rdy, 0);
      check("arst_word_cnt",  word_cnt, 0);
      check("arst_checksum",  checksum, 0);
      check("arst_peak_occ",  peak_occ, 0);
      #2;
      rst_n = 1'b1;
      step();
      check("post_out_vld",   out_vld,  0);
      check("post_word_cnt",  word_cnt, 0);
      check("post_data_rdy",  data_rdy, 1);
`endif

      // Random stream with random consumer stalls
      do_reset();
      xor_model = '0;
      for (int k = 0; k < N; k++) begin
         words[k]  = {$urandom(), $urandom()};
         xor_model = xor_model ^ words[k];
      end
      sent      = 0;
      rcv       = 0;
      occ_model = 0;
      throttled = 0;
      cyc       = 0;
      while ((rcv < N) && (cyc < 20000)) begin
         data_vld = (sent < N);
         data     = (sent < N) ? words[sent] : 64'h0;
         out_rdy  = ($urandom_range(0, 3) != 0);
         #1;
         do_push = data_vld && data_rdy;
         do_pop  = out_vld && out_rdy;
         if (!data_rdy && (occ_model < DEPTH)) begin
            throttled++;
         end
         if (do_pop) begin
            check("stream_order", out_data, words[rcv]);
            rcv++;
         end
         if (do_push) begin
            sent++;
         end
         occ_model = occ_model + int'(do_push) - int'(do_pop);
         step();
         cyc++;
      end
      data_vld = 1'b0;
      out_rdy  = 1'b0;
      check("stream_rcv",      64'(rcv), 64'(N));
      check("stream_word_cnt", word_cnt, 64'(N));
      check("stream_checksum", checksum, xor_model);
      check("stream_sat_cnt",  s_word_cnt, 3'd7);
`ifdef CPU_MULTISIM_SINK_THROTTLE_EN
      check("throttle_seen",   64'(throttled > 0), 1);
`else
      check("no_throttle",     64'(throttled), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
